// File: rtl/full_adder_64_reg_pkg.sv
// Bit-level helpers shared by the ripple-carry adder slice.
// Each full-adder cell uses these for its sum and carry equations.
package full_adder_64_reg_pkg;

    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_64_reg_if.sv
// Operand/result bundle for the registered ripple adder.
// The master drives the operands and the slave returns the sum.
interface full_adder_64_reg_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             carry;

    modport master (output a, output b, output cin, input  s, input  carry);
    modport slave  (input  a, input  b, input  cin, output s, output carry);
endinterface

// File: rtl/full_adder_64_reg_full_adder_1b.sv
// One-bit full-adder cell, purely combinational.
// Instances are chained cout -> cin to form the ripple-carry adder.
module full_adder_1b
    import full_adder_64_reg_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = xor3(a, b, cin);
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder_64_reg.sv
// Ripple-carry adder {carry, s} = a + b + cin with a registered result.
// One cycle of latency and a new result every clock.
module full_adder_64_reg #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    full_adder_64_reg_if.slave bus
);

    logic [WIDTH:0]   c_p0;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] s_p1;
    logic             carry_p1;

    // Stage 0: combinational ripple chain, operands taken straight from the bus
    assign c_p0[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1b u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (c_p0[i]),
            .s    (sum_p0[i]),
            .cout (c_p0[i+1])
        );
    end

    // Stage 1: result register, cleared at once by reset with no clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p1     <= '0;
            carry_p1 <= 1'b0;
        end else begin
            s_p1     <= sum_p0;
            carry_p1 <= c_p0[WIDTH];
        end
    end

    assign bus.s     = s_p1;
    assign bus.carry = carry_p1;

endmodule

// File: tb/tb_full_adder_64_reg.sv
// Scoreboard bench for full_adder_64_reg: the driver queues expected results,
// a monitor pops and compares one cycle later.
module tb_full_adder_64_reg;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    full_adder_64_reg_if #(.WIDTH(W)) bus ();

    full_adder_64_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act_s, input logic act_c,
                         input logic [W-1:0] exp_s, input logic exp_c);
        tests++;
        if (act_s !== exp_s || act_c !== exp_c) begin
            fails++;
            $display("FAIL %s: got s=%h carry=%b, expected s=%h carry=%b",
                     nm, act_s, act_c, exp_s, exp_c);
        end
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input string nm);
        exp_t e;
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        e.s = es;
        e.c = ec;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: the result is presented every cycle, checked just after the edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check(e.name, bus.s, bus.carry, e.s, e.c);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rsum;

        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        #1;
        check("reset_state", bus.s, bus.carry, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply(64'h0, 64'h0, 1'b0, 64'h0, 1'b0, "zero");
        apply(64'h1, 64'h1, 1'b1, 64'h3, 1'b0, "ones_cin");
        apply(64'h6, 64'hC, 1'b1, 64'h13, 1'b0, "six_twelve");
        apply(64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFE8, 1'b1, "wrap_a");
        apply(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF0, 1'b1, "wrap_b");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "all_ones");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, "full_ripple");
        apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              64'h0, 1'b1, "msb_carry");
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, "signed_ovf_no_carry");
        apply(64'h0, 64'h0, 1'b1, 64'h1, 1'b0, "cin_only");

        // Reset between edges: pending result is dropped, output clears at once
        @(negedge clk);
        bus.a   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.cin = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.s, bus.carry, '0, 1'b0);
        @(negedge clk);
        check("held_in_reset", bus.s, bus.carry, '0, 1'b0);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.s = 64'hFFFF_FFFF_FFFF_FFFF;
            e.c = 1'b1;
            e.name = "after_release";
            q.push_back(e);
        end
        #1;
        check("no_early_result", bus.s, bus.carry, '0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rc   = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            apply(ra, rb, rc, rsum[W-1:0], rsum[W], "random");
        end

        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
